// File: rtl/cordic_range_reducer_if.sv
// cordic_range_reducer_if: angle-in, result-out and CORDIC launch/return signals of the range reducer.
interface cordic_range_reducer_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] angle_in;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] sin_out;
  logic signed [23:0] cos_out;
  logic               cordic_start;
  logic signed [23:0] cordic_angle;
  logic               cordic_ready;
  logic signed [23:0] cordic_sin;
  logic signed [23:0] cordic_cos;
  modport master (
    output in_valid, angle_in, out_ready, cordic_ready, cordic_sin, cordic_cos,
    input  in_ready, out_valid, sin_out, cos_out, cordic_start, cordic_angle
  );
  modport slave (
    input  in_valid, angle_in, out_ready, cordic_ready, cordic_sin, cordic_cos,
    output in_ready, out_valid, sin_out, cos_out, cordic_start, cordic_angle
  );
endinterface

// File: rtl/cordic_range_reducer.sv
// cordic_range_reducer: wraps a Q8.16 angle into [-pi, pi], folds it into [-pi/2, pi/2] for the CORDIC,
// and sign-corrects the returned cosine.
module cordic_range_reducer #(
  parameter int GUARD_CYCLES = 1
) (
  input logic                  clk,
  input logic                  reset,
  cordic_range_reducer_if.slave bus
);
  localparam logic signed [24:0] PI       = 25'sh03243F;
  localparam logic signed [24:0] NEG_PI   = -PI;
  localparam logic signed [24:0] TWO_PI   = 25'sh06487F;
  localparam logic signed [24:0] HALF_PI  = 25'sh01921F;
  localparam logic signed [24:0] NEG_HALF = -HALF_PI;
  typedef enum logic [2:0] {IDLE, REDUCE, FOLD, LAUNCH, GUARD, WAIT, HOLD} state_t;
  state_t             state_q, state_d;
  logic signed [24:0] a_q, a_d;
  logic signed [23:0] angle_q, angle_d, sin_q, sin_d, cos_q, cos_d, cos_neg;
  logic               neg_cos_q, neg_cos_d;
  logic [1:0]         guard_q, guard_d;
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    angle_d   = angle_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    neg_cos_d = neg_cos_q;
    guard_d   = guard_q;
    cos_neg   = bus.cordic_cos == 24'sh800000 ? 24'sh7FFFFF : -bus.cordic_cos;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = {bus.angle_in[23], bus.angle_in};
        state_d = REDUCE;
      end
      REDUCE: begin
        a_d     = a_q > PI ? a_q - TWO_PI : a_q < NEG_PI ? a_q + TWO_PI : a_q;
        state_d = (a_q > PI || a_q < NEG_PI) ? REDUCE : FOLD;
      end
      FOLD: begin
        angle_d   = a_q > HALF_PI ? 24'(PI - a_q) : a_q < NEG_HALF ? 24'(NEG_PI - a_q) : 24'(a_q);
        neg_cos_d = a_q > HALF_PI || a_q < NEG_HALF;
        state_d   = LAUNCH;
      end
      LAUNCH: begin
        guard_d = 2'(GUARD_CYCLES - 1);
        state_d = GUARD;
      end
      GUARD: begin
        guard_d = guard_q - 2'd1;
        state_d = guard_q == 2'd0 ? WAIT : GUARD;
      end
      WAIT: if (bus.cordic_ready) begin
        sin_d   = bus.cordic_sin;
        cos_d   = neg_cos_q ? cos_neg : bus.cordic_cos;
        state_d = HOLD;
      end
      HOLD: state_d = bus.out_ready ? IDLE : HOLD;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      angle_q   <= '0;
      sin_q     <= '0;
      cos_q     <= '0;
      neg_cos_q <= 1'b0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      angle_q   <= angle_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      neg_cos_q <= neg_cos_d;
      guard_q   <= guard_d;
    end
  end
  assign bus.in_ready     = state_q == IDLE;
  assign bus.out_valid    = state_q == HOLD;
  assign bus.cordic_start = state_q == LAUNCH;
  assign bus.cordic_angle = angle_q;
  assign bus.sin_out      = sin_q;
  assign bus.cos_out      = cos_q;
endmodule

// File: tb/tb_cordic_range_reducer.sv
// tb_cordic_range_reducer: drives angles into cordic_range_reducer against a delayed CORDIC responder
// and compares results, folded angles and latency with an arithmetic reference model.
module tb_cordic_range_reducer;
  localparam int G       = 1;
  localparam int PI      = 205887;
  localparam int TWO_PI  = 411775;
  localparam int HALF_PI = 102943;
  logic clk = 0;
  logic reset = 0;
  int checks = 0;
  int errors = 0;
  cordic_range_reducer_if bus();
  cordic_range_reducer #(.GUARD_CYCLES(G)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [23:0] model_sin = 0;
  logic [23:0] model_cos = 0;
  int          model_delay = 1;
  logic        m_ready = 0;
  int          m_cnt = 0;
  int          starts = 0;
  logic [23:0] last_angle = 0;
  assign bus.cordic_ready = m_ready;
  assign bus.cordic_sin   = model_sin;
  assign bus.cordic_cos   = model_cos;
  // CORDIC stand-in: ready drops on start and rises model_delay edges later
  always @(posedge clk) begin
    if (bus.cordic_start) begin
      m_cnt      <= model_delay;
      m_ready    <= 1'b0;
      starts     <= starts + 1;
      last_angle <= bus.cordic_angle;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_ready <= 1'b1;
    end
  end
  function automatic void ref_model(input logic [23:0] ang, output int k, output logic [23:0] fa, output bit nc);
    int a;
    a = int'($signed(ang));
    k = 0;
    if (a > PI) begin
      k = (a - PI + TWO_PI - 1) / TWO_PI;
      a -= k * TWO_PI;
    end else if (a < -PI) begin
      k = (-PI - a + TWO_PI - 1) / TWO_PI;
      a += k * TWO_PI;
    end
    nc = a > HALF_PI || a < -HALF_PI;
    fa = 24'(a > HALF_PI ? PI - a : a < -HALF_PI ? -PI - a : a);
  endfunction
  function automatic logic [23:0] ref_cos(input logic [23:0] c, input bit nc);
    return !nc ? c : c == 24'h800000 ? 24'h7FFFFF : 24'(-int'($signed(c)));
  endfunction
  function automatic int ref_latency(input int k, input int d);
    int l;
    l = d + 1 - G;
    return k + 4 + G + l;
  endfunction
  task automatic run_op(input logic [23:0] ang, input logic [23:0] s, input logic [23:0] c, input int d,
                        output int lat, output logic [23:0] oa, output int ns,
                        output logic [23:0] os, output logic [23:0] oc, output bit busy_ok);
    int s0;
    model_sin = s;
    model_cos = c;
    model_delay = d;
    s0 = starts;
    busy_ok = 1;
    @(negedge clk);
    bus.angle_in = ang;
    bus.in_valid = 1;
    @(posedge clk);
    #1 bus.in_valid = 0;
    lat = 1;
    while (!bus.out_valid && lat < 300) begin
      if (bus.in_ready) busy_ok = 0;
      @(posedge clk);
      #1 lat++;
    end
    oa = last_angle;
    ns = starts - s0;
    os = bus.sin_out;
    oc = bus.cos_out;
  endtask
  task automatic accept_out();
    @(negedge clk);
    bus.out_ready = 1;
    @(posedge clk);
    #1 bus.out_ready = 0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.cordic_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.cordic_start); end
    checks++; if ({bus.cordic_angle, bus.sin_out, bus.cos_out} !== 72'h0) begin errors++; $display("FAIL reset_regs: got %h/%h/%h expected 0/0/0", bus.cordic_angle, bus.sin_out, bus.cos_out); end
  endtask
  task automatic test_directed();
    logic [23:0] t_ang [12] = '{24'h000000, 24'h00C90F, 24'h03243F, 24'h07118E, 24'hFDA4D0, 24'h7FFFFF,
                                24'h800000, 24'hFCDBC1, 24'h01921F, 24'hFE6DE1, 24'h01921E, 24'h000001};
    logic [23:0] t_sin [12] = '{24'h000000, 24'h00B505, 24'h000000, 24'h00B505, 24'hFF4AFB, 24'h123456,
                                24'hFEDCBA, 24'h000000, 24'h010000, 24'hFF0000, 24'h00FFFF, 24'h000001};
    logic [23:0] t_cos [12] = '{24'h010000, 24'h00B505, 24'h010000, 24'h00B505, 24'h00B505, 24'h800000,
                                24'h7FFFFF, 24'h010000, 24'h000000, 24'h000001, 24'h800000, 24'h010000};
    int t_d [12] = '{18, 5, 3, 5, 4, 2, 1, 7, 1, 2, 3, 1};
    int k, lat, ns;
    logic [23:0] fa, oa, os, oc;
    bit nc, busy_ok;
    for (int i = 0; i < 12; i++) begin
      ref_model(t_ang[i], k, fa, nc);
      run_op(t_ang[i], t_sin[i], t_cos[i], t_d[i], lat, oa, ns, os, oc, busy_ok);
      checks++; if (lat !== ref_latency(k, t_d[i])) begin errors++; $display("FAIL dir_latency ang=%h: got %0d expected %0d", t_ang[i], lat, ref_latency(k, t_d[i])); end
      checks++; if (oa !== fa) begin errors++; $display("FAIL dir_cordic_angle ang=%h: got %h expected %h", t_ang[i], oa, fa); end
      checks++; if (ns !== 1) begin errors++; $display("FAIL dir_start_pulses ang=%h: got %0d expected 1", t_ang[i], ns); end
      checks++; if (os !== t_sin[i]) begin errors++; $display("FAIL dir_sin ang=%h: got %h expected %h", t_ang[i], os, t_sin[i]); end
      checks++; if (oc !== ref_cos(t_cos[i], nc)) begin errors++; $display("FAIL dir_cos ang=%h: got %h expected %h", t_ang[i], oc, ref_cos(t_cos[i], nc)); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL dir_in_ready_busy ang=%h: got 1 expected 0", t_ang[i]); end
      accept_out();
    end
  endtask
  task automatic test_backpressure();
    int k, lat, ns;
    logic [23:0] fa, oa, os, oc;
    bit nc, busy_ok, stable;
    ref_model(24'h03243F, k, fa, nc);
    run_op(24'h03243F, 24'h00ABCD, 24'h00F00D, 6, lat, oa, ns, os, oc, busy_ok);
    stable = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.in_ready || bus.sin_out !== 24'h00ABCD || bus.cos_out !== ref_cos(24'h00F00D, nc)) stable = 0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL backpressure_hold: got valid=%b ready=%b sin=%h cos=%h expected held result", bus.out_valid, bus.in_ready, bus.sin_out, bus.cos_out); end
    accept_out();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL handshake_valid_drop: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL handshake_in_ready: got %b expected 1", bus.in_ready); end
  endtask
  task automatic test_reset_mid_wait();
    int k, lat, ns;
    logic [23:0] fa, oa, os, oc;
    bit nc, busy_ok, seen;
    model_sin = 24'h111111;
    model_cos = 24'h222222;
    model_delay = 30;
    @(negedge clk);
    bus.angle_in = 24'h00C90F;
    bus.in_valid = 1;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (8) @(negedge clk);
    checks++; if (bus.cordic_angle !== 24'h00C90F) begin errors++; $display("FAIL pre_reset_angle: got %h expected 00c90f", bus.cordic_angle); end
    reset = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.cordic_start !== 1'b0) begin errors++; $display("FAIL midwait_reset_ctrl: got valid=%b start=%b expected 0/0", bus.out_valid, bus.cordic_start); end
    checks++; if ({bus.cordic_angle, bus.sin_out, bus.cos_out} !== 72'h0) begin errors++; $display("FAIL midwait_reset_regs: got %h/%h/%h expected 0/0/0", bus.cordic_angle, bus.sin_out, bus.cos_out); end
    @(negedge clk);
    reset = 1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL late_cordic_ready: got out_valid=1 expected 0"); end
    ref_model(24'hFDA4D0, k, fa, nc);
    run_op(24'hFDA4D0, 24'h00ABCD, 24'h001234, 3, lat, oa, ns, os, oc, busy_ok);
    checks++; if (oa !== fa || os !== 24'h00ABCD || oc !== ref_cos(24'h001234, nc)) begin errors++; $display("FAIL post_reset_op: got %h/%h/%h expected %h/00abcd/%h", oa, os, oc, fa, ref_cos(24'h001234, nc)); end
    checks++; if (lat !== ref_latency(k, 3)) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", lat, ref_latency(k, 3)); end
    accept_out();
  endtask
  task automatic test_random();
    int k, lat, ns, d;
    logic [23:0] ang, s, c, fa, oa, os, oc;
    bit nc, busy_ok;
    for (int i = 0; i < 30; i++) begin
      ang = 24'($urandom);
      s = 24'($urandom);
      c = ($urandom_range(0, 4) == 0) ? 24'h800000 : 24'($urandom);
      d = $urandom_range(G, 20);
      ref_model(ang, k, fa, nc);
      run_op(ang, s, c, d, lat, oa, ns, os, oc, busy_ok);
      checks++; if (lat !== ref_latency(k, d)) begin errors++; $display("FAIL rnd_latency ang=%h: got %0d expected %0d", ang, lat, ref_latency(k, d)); end
      checks++; if (oa !== fa || ns !== 1) begin errors++; $display("FAIL rnd_launch ang=%h: got angle=%h starts=%0d expected %h/1", ang, oa, ns, fa); end
      checks++; if (os !== s || oc !== ref_cos(c, nc)) begin errors++; $display("FAIL rnd_result ang=%h: got %h/%h expected %h/%h", ang, os, oc, s, ref_cos(c, nc)); end
      checks++; if (!busy_ok) begin errors++; $display("FAIL rnd_in_ready_busy ang=%h: got 1 expected 0", ang); end
      accept_out();
    end
  endtask
  initial begin
    bus.in_valid = 0;
    bus.angle_in = 0;
    bus.out_ready = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
